// File: rtl/ram_arb_2to1.sv
// Two-master round-robin arbiter in front of one single-port RAM slave.
// A small read-ID FIFO steers in-order read responses back to their issuer.
module ram_arb_2to1 #(
  parameter int dat_width = 32,
  parameter int adr_width = 32,
  parameter int rd_depth  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,

  input  logic                   m0_req_i,
  input  logic                   m0_we_i,
  input  logic [adr_width-1:0]   m0_addr_bi,
  input  logic [dat_width/8-1:0] m0_be_bi,
  input  logic [dat_width-1:0]   m0_wdata_bi,
  output logic                   m0_ack_o,
  output logic                   m0_resp_o,
  output logic [dat_width-1:0]   m0_rdata_bo,

  input  logic                   m1_req_i,
  input  logic                   m1_we_i,
  input  logic [adr_width-1:0]   m1_addr_bi,
  input  logic [dat_width/8-1:0] m1_be_bi,
  input  logic [dat_width-1:0]   m1_wdata_bi,
  output logic                   m1_ack_o,
  output logic                   m1_resp_o,
  output logic [dat_width-1:0]   m1_rdata_bo,

  output logic                   s_req_o,
  output logic                   s_we_o,
  output logic [adr_width-1:0]   s_addr_bo,
  output logic [dat_width/8-1:0] s_be_bo,
  output logic [dat_width-1:0]   s_wdata_bo,
  input  logic                   s_ack_i,
  input  logic                   s_resp_i,
  input  logic [dat_width-1:0]   s_rdata_bi,

  output logic                   err_o
);

  localparam int bw = dat_width / 8;
  localparam int pw = $clog2(rd_depth);
  localparam int cw = pw + 1;
  localparam logic [cw-1:0] full_c = cw'(rd_depth);

  logic                last;
  logic                lock;
  logic                lock_id;
  logic                err;
  logic [rd_depth-1:0] ids;
  logic [pw-1:0]       wp;
  logic [pw-1:0]       rp;
  logic [cw-1:0]       cnt;

  logic                any_req;
  logic                gnt;
  logic                g_req;
  logic                g_we;
  logic                blk;
  logic                acc;
  logic                push;
  logic                pop;
  logic                head;

  assign any_req = m0_req_i | m1_req_i;

  always_comb begin
    gnt = 1'b0;
    if (lock)
      gnt = lock_id;
    else if (m0_req_i && m1_req_i)
      gnt = ~last;
    else if (m1_req_i)
      gnt = 1'b1;
  end

  assign g_req = gnt ? m1_req_i : m0_req_i;
  assign g_we  = gnt ? m1_we_i  : m0_we_i;

  // A full ID FIFO stalls reads only; a same-cycle pop does not free a slot.
  assign blk = g_req & ~g_we & (cnt == full_c);

  always_comb begin
    s_req_o    = g_req & ~blk;
    s_we_o     = 1'b0;
    s_addr_bo  = '0;
    s_be_bo    = '0;
    s_wdata_bo = '0;
    if (any_req) begin
      s_we_o     = g_we;
      s_addr_bo  = gnt ? m1_addr_bi  : m0_addr_bi;
      s_be_bo    = gnt ? m1_be_bi    : m0_be_bi;
      s_wdata_bo = gnt ? m1_wdata_bi : m0_wdata_bi;
    end
  end

  assign acc  = s_req_o & s_ack_i;
  assign push = acc & ~g_we;
  assign pop  = s_resp_i & (cnt != '0);
  assign head = ids[rp];

  assign m0_ack_o    = acc & ~gnt;
  assign m1_ack_o    = acc & gnt;
  assign m0_resp_o   = pop & ~head;
  assign m1_resp_o   = pop & head;
  assign m0_rdata_bo = s_rdata_bi;
  assign m1_rdata_bo = s_rdata_bi;
  assign err_o       = err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last    <= 1'b1;
      lock    <= 1'b0;
      lock_id <= 1'b0;
    end else if (acc) begin
      last <= gnt;
      lock <= 1'b0;
    end else if (s_req_o) begin
      lock    <= 1'b1;
      lock_id <= gnt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ids <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        ids[wp] <= gnt;
        wp      <= wp + pw'(1);
      end
      if (pop)
        rp <= rp + pw'(1);
      if (push && !pop)
        cnt <= cnt + cw'(1);
      else if (pop && !push)
        cnt <= cnt - cw'(1);
    end
  end

  // Response with nothing outstanding is a protocol violation; keep it sticky.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      err <= 1'b0;
    else if (s_resp_i && cnt == '0)
      err <= 1'b1;
  end

  logic unused_bw;
  assign unused_bw = (bw == 0);

endmodule

// File: tb/tb_ram_arb_2to1.sv
// Directed bench for ram_arb_2to1: vector table plus scoreboarded
// round-robin read stream and reset corner sequences.
module tb_ram_arb_2to1;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;

  logic        m0_req_i, m0_we_i;
  logic [31:0] m0_addr_bi, m0_wdata_bi;
  logic [3:0]  m0_be_bi;
  logic        m0_ack_o, m0_resp_o;
  logic [31:0] m0_rdata_bo;

  logic        m1_req_i, m1_we_i;
  logic [31:0] m1_addr_bi, m1_wdata_bi;
  logic [3:0]  m1_be_bi;
  logic        m1_ack_o, m1_resp_o;
  logic [31:0] m1_rdata_bo;

  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_bo, s_wdata_bo;
  logic [3:0]  s_be_bo;
  logic        s_ack_i, s_resp_i;
  logic [31:0] s_rdata_bi;
  logic        err_o;

  ram_arb_2to1 #(
    .dat_width(32),
    .adr_width(32),
    .rd_depth (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .m0_req_i   (m0_req_i),
    .m0_we_i    (m0_we_i),
    .m0_addr_bi (m0_addr_bi),
    .m0_be_bi   (m0_be_bi),
    .m0_wdata_bi(m0_wdata_bi),
    .m0_ack_o   (m0_ack_o),
    .m0_resp_o  (m0_resp_o),
    .m0_rdata_bo(m0_rdata_bo),
    .m1_req_i   (m1_req_i),
    .m1_we_i    (m1_we_i),
    .m1_addr_bi (m1_addr_bi),
    .m1_be_bi   (m1_be_bi),
    .m1_wdata_bi(m1_wdata_bi),
    .m1_ack_o   (m1_ack_o),
    .m1_resp_o  (m1_resp_o),
    .m1_rdata_bo(m1_rdata_bo),
    .s_req_o    (s_req_o),
    .s_we_o     (s_we_o),
    .s_addr_bo  (s_addr_bo),
    .s_be_bo    (s_be_bo),
    .s_wdata_bo (s_wdata_bo),
    .s_ack_i    (s_ack_i),
    .s_resp_i   (s_resp_i),
    .s_rdata_bi (s_rdata_bi),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0;
    logic        r1, w1;
    logic [31:0] a1;
    logic        ack, resp;
    logic [31:0] rd;
    logic        esr, ewe;
    logic [31:0] ea;
    logic        ea0, ea1, ep0, ep1, eer;
  } vec_t;

  typedef struct {
    logic        g;
    logic [31:0] d;
  } rd_t;

  vec_t tbl[$];
  rd_t  sb[$];
  int   nvec = 0;
  int   nmis = 0;

  function automatic vec_t mk(
    input logic r0, w0, input logic [31:0] a0,
    input logic r1, w1, input logic [31:0] a1,
    input logic ack, resp, input logic [31:0] rd,
    input logic esr, ewe, input logic [31:0] ea,
    input logic ea0, ea1, ep0, ep1, eer);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1;
    v.ack = ack; v.resp = resp; v.rd = rd;
    v.esr = esr; v.ewe = ewe; v.ea = ea;
    v.ea0 = ea0; v.ea1 = ea1; v.ep0 = ep0; v.ep1 = ep1; v.eer = eer;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    m0_req_i    = v.r0;
    m0_we_i     = v.w0;
    m0_addr_bi  = v.a0;
    m0_be_bi    = v.a0[7:4];
    m0_wdata_bi = ~v.a0;
    m1_req_i    = v.r1;
    m1_we_i     = v.w1;
    m1_addr_bi  = v.a1;
    m1_be_bi    = v.a1[7:4];
    m1_wdata_bi = ~v.a1;
    s_ack_i     = v.ack;
    s_resp_i    = v.resp;
    s_rdata_bi  = v.rd;
  endtask

  function automatic vec_t idle();
    return mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0);
  endfunction

  task automatic check(input string nm, input logic [159:0] a,
                       input logic [159:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  function automatic logic [159:0] act_pk();
    return {s_req_o, s_we_o, s_addr_bo, s_be_bo, s_wdata_bo,
            m0_ack_o, m1_ack_o, m0_resp_o, m1_resp_o, err_o,
            m0_rdata_bo, m1_rdata_bo};
  endfunction

  function automatic logic [159:0] exp_pk(input vec_t v);
    logic any;
    any = v.r0 | v.r1;
    return {v.esr, v.ewe, v.ea, any ? v.ea[7:4] : 4'h0,
            any ? ~v.ea : 32'h0,
            v.ea0, v.ea1, v.ep0, v.ep1, v.eer, v.rd, v.rd};
  endfunction

  task automatic apply(input string nm, input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check(nm, act_pk(), exp_pk(v));
  endtask

  initial begin
    vec_t v;
    logic g;
    logic have;

    drive(idle());
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      v = mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, 0,0,0, 0,0,0,0,0);
      drive(v);
    end
    apply("reset_idle", idle());
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(negedge clk);
    check("post_reset_idle", act_pk(), exp_pk(idle()));

    g = 1'b0;
    for (int k = 0; k < 9; k++) begin
      logic [3:0] ex;
      @(posedge clk);
      #1;
      have = (sb.size() > 0);
      v = idle();
      if (k < 8) begin
        v.r0 = 1; v.a0 = 32'h10;
        v.r1 = 1; v.a1 = 32'h20;
        v.ack = 1;
      end
      v.resp = have;
      v.rd   = have ? sb[0].d : 32'h0;
      drive(v);
      @(negedge clk);
      ex = {k < 8 && !g, k < 8 && g,
            have && !sb[0].g, have && sb[0].g};
      check($sformatf("tie_%0d", k),
            {s_addr_bo, m0_ack_o, m1_ack_o, m0_resp_o, m1_resp_o,
             m0_rdata_bo, m1_rdata_bo},
            {(k < 8) ? (g ? 32'h20 : 32'h10) : 32'h0, ex, v.rd, v.rd});
      if (have)
        void'(sb.pop_front());
      if (k < 8) begin
        sb.push_back('{g: g, d: $urandom});
        g = ~g;
      end
    end

    tbl.push_back(mk(0,0,0, 1,1,'h40, 0,0,0, 1,1,'h40, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,'h40, 0,0,0, 1,1,'h40, 0,0,0,0,0));
    tbl.push_back(mk(1,0,'h10, 1,1,'h40, 0,0,0, 1,1,'h40, 0,0,0,0,0));
    tbl.push_back(mk(1,0,'h10, 1,1,'h40, 1,0,0, 1,1,'h40, 0,1,0,0,0));
    tbl.push_back(mk(1,0,'h10, 0,0,0, 1,0,0, 1,0,'h10, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,1,'hA5A5, 0,0,0, 0,0,1,0,0));

    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,0,'h100 + 4*i, 0,0,0, 1,0,0,
                       1,0,'h100 + 4*i, 1,0,0,0,0));
    tbl.push_back(mk(1,0,'h110, 0,0,0, 1,0,0, 0,0,'h110, 0,0,0,0,0));
    tbl.push_back(mk(1,0,'h110, 1,1,'h200, 1,0,0, 1,1,'h200, 0,1,0,0,0));
    tbl.push_back(mk(1,0,'h110, 0,0,0, 1,1,'h1111, 0,0,'h110, 0,0,1,0,0));
    tbl.push_back(mk(1,0,'h110, 0,0,0, 1,0,0, 1,0,'h110, 1,0,0,0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0, 0,0,0, 0,1,'h5000 + i, 0,0,0, 0,0,1,0,0));

    tbl.push_back(mk(0,0,0, 1,0,'h300, 1,0,0, 1,0,'h300, 0,1,0,0,0));
    tbl.push_back(mk(1,0,'h310, 0,0,0, 1,0,0, 1,0,'h310, 1,0,0,0,0));
    tbl.push_back(mk(1,0,'h320, 0,0,0, 1,1,'h2222, 1,0,'h320, 1,0,0,1,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,1,'h3333, 0,0,0, 0,0,1,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,1,'h3334, 0,0,0, 0,0,1,0,0));
    tbl.push_back(idle());

    tbl.push_back(mk(0,0,0, 0,0,0, 0,1,'h4444, 0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,1));

    foreach (tbl[i])
      apply($sformatf("vec_%0d", i), tbl[i]);

    @(posedge clk);
    #1;
    drive(idle());
    rst_i = 1'b0;
    @(negedge clk);
    check("err_cleared", {159'h0, err_o}, 160'h0);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    apply("mid_read", mk(1,0,'h500, 0,0,0, 1,0,0, 1,0,'h500, 1,0,0,0,0));
    @(posedge clk);
    #1;
    drive(idle());
    rst_i = 1'b0;
    #2;
    rst_i = 1'b1;
    @(negedge clk);
    check("mid_reset_idle", act_pk(), exp_pk(idle()));
    apply("dropped_resp", mk(0,0,0, 0,0,0, 0,1,'h6666, 0,0,0, 0,0,0,0,0));
    apply("dropped_err", mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
